// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 command issuer.
// Holds opcode/stat encodings, the issuer FSM state type and device sizes.
package ats21_pkg;

    localparam int NUM_ALARMS = 24;
    localparam int NUM_CLOCKS = 4;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_SET_CLK = 3'b001,
        OP_EN_CLK  = 3'b010,
        OP_MODE    = 3'b011,
        OP_SET_ALM = 3'b101,
        OP_SET_TMR = 3'b110,
        OP_EN_ALM  = 3'b111
    } op_e;

    typedef enum logic {
        STAT_NACK = 1'b0,
        STAT_ACK  = 1'b1
    } stat_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT_HI,
        ST_BEAT_LO,
        ST_RESP
    } iss_state_e;

    function automatic logic is_nop(input logic [2:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Per-client synchronous command FIFO (power-of-two DEPTH).
// Ports: push/push_data in, pop in, head/head_nxt out (entry after head),
// two (>=2 entries), full, empty. Push while full is accepted with a pop.
module ats21_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_1x,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_nxt,
    output logic             two,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [AW:0]      cnt_q;
    logic             wr;
    logic             rd;

    assign full     = cnt_q == (AW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign two      = cnt_q > (AW+1)'(1);
    assign wr       = push && (!full || pop);
    assign rd       = pop && !empty;
    assign head     = mem_q[rp_q];
    assign head_nxt = mem_q[rp_q + AW'(1)];

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + AW'(1);
            if (rd) rp_q <= rp_q + AW'(1);
            unique case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_1x) begin
        if (wr) mem_q[wp_q] <= push_data;
    end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ATS21 client-side initiator: two command FIFOs, two-beat bus FSM with
// per-client Ack/Nack handling, and sticky alarm capture with interrupt.
// Ports: cmd_* (A/B command in), rsp_* (A/B completion), req/ctrlA/ctrlB/
// stat (ATS21 bus), data/alarm_clr/alarm_pending/alarm_irq (alarms).
// Build option: ATS21_ISSUER_RETRY_EN enables Nack retry up to MAX_RETRY.
module ats21_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 3,
    parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS
) (
    input  logic                  clk_1x,
    input  logic                  reset,
    input  logic                  cmd_valid_a,
    input  logic [31:0]           cmd_data_a,
    output logic                  cmd_ready_a,
    input  logic                  cmd_valid_b,
    input  logic [31:0]           cmd_data_b,
    output logic                  cmd_ready_b,
    output logic                  rsp_valid_a,
    output logic                  rsp_ack_a,
    output logic                  rsp_valid_b,
    output logic                  rsp_ack_b,
    output logic                  req,
    output logic [15:0]           ctrlA,
    output logic [15:0]           ctrlB,
    input  logic [1:0]            stat,
    input  logic [NUM_ALARMS-1:0] data,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);

    import ats21_pkg::*;

    // Index 0 is client A, index 1 is client B.
    logic [1:0]        cvalid;
    logic [1:0][31:0]  cdata;
    logic [1:0]        push, pop, full, empty, two;
    logic [1:0][31:0]  head, nxt, sel;
    logic [1:0]        ack, stay, done, go, nop_rsp, retry_left;

    iss_state_e        state_q;
    logic [1:0]        part_q;
    logic              req_q;
    logic [1:0][15:0]  ctrl_q;
    logic [1:0][15:0]  lo_q;
    logic [1:0]        rsp_v_q;
    logic [1:0]        rsp_ack_q;

    logic [NUM_ALARMS-1:0] data_q;
    logic [NUM_ALARMS-1:0] pend_q;

    assign cvalid = {cmd_valid_b, cmd_valid_a};
    assign cdata  = {cmd_data_b, cmd_data_a};

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        assign push[c] = cvalid[c] && !full[c];
        ats21_cmd_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (32)
        ) u_fifo (
            .clk_1x    (clk_1x),
            .reset     (reset),
            .push      (push[c]),
            .push_data (cdata[c]),
            .pop       (pop[c]),
            .head      (head[c]),
            .head_nxt  (nxt[c]),
            .two       (two[c]),
            .full      (full[c]),
            .empty     (empty[c])
        );
    end

`ifdef ATS21_ISSUER_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [1:0][RW-1:0] rcnt_q;

    always_comb begin
        for (int c = 0; c < 2; c++)
            retry_left[c] = rcnt_q[c] < RW'(MAX_RETRY);
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            rcnt_q <= '0;
        end else if (state_q == ST_RESP) begin
            for (int c = 0; c < 2; c++)
                if (part_q[c])
                    rcnt_q[c] <= stay[c] ? rcnt_q[c] + RW'(1) : '0;
        end
    end
`else
    // Retry limit has no effect in this build.
    logic unused_retry;
    assign unused_retry = ^MAX_RETRY;
    assign retry_left   = '0;
`endif

    // Launch selection: on completion in RESP the next command is the
    // entry behind the head being popped, so back-to-back needs no IDLE.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ack[c]     = stat[c] == STAT_ACK;
            stay[c]    = part_q[c] && !ack[c] && retry_left[c];
            done[c]    = state_q == ST_RESP && part_q[c] && !stay[c];
            // A registered pulse owns this cycle; the nop waits one.
            nop_rsp[c] = state_q == ST_IDLE && !empty[c] &&
                         is_nop(head[c][31:29]) && !rsp_v_q[c];
            pop[c]     = done[c] || nop_rsp[c];
            go[c]      = 1'b0;
            sel[c]     = head[c];
            if (state_q == ST_IDLE) begin
                go[c] = !empty[c] && !is_nop(head[c][31:29]);
            end else if (state_q == ST_RESP) begin
                if (done[c]) begin
                    go[c]  = two[c] && !is_nop(nxt[c][31:29]);
                    sel[c] = nxt[c];
                end else if (stay[c]) begin
                    go[c] = 1'b1;
                end else begin
                    go[c] = !empty[c] && !is_nop(head[c][31:29]);
                end
            end
        end
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            part_q    <= '0;
            req_q     <= 1'b0;
            ctrl_q    <= '0;
            lo_q      <= '0;
            rsp_v_q   <= '0;
            rsp_ack_q <= '0;
        end else begin
            rsp_v_q   <= done;
            rsp_ack_q <= done & ack;
            unique case (state_q)
                ST_IDLE, ST_RESP: begin
                    part_q  <= go;
                    req_q   <= |go;
                    state_q <= (|go) ? ST_BEAT_HI : ST_IDLE;
                    for (int c = 0; c < 2; c++) begin
                        ctrl_q[c] <= go[c] ? sel[c][31:16] : 16'h0000;
                        lo_q[c]   <= sel[c][15:0];
                    end
                end
                ST_BEAT_HI: begin
                    state_q <= ST_BEAT_LO;
                    for (int c = 0; c < 2; c++)
                        ctrl_q[c] <= part_q[c] ? lo_q[c] : 16'h0000;
                end
                ST_BEAT_LO: begin
                    state_q <= ST_RESP;
                    req_q   <= 1'b0;
                    ctrl_q  <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            pend_q <= '0;
        end else begin
            data_q <= data;
            pend_q <= (pend_q & ~alarm_clr) | (data & ~data_q);
        end
    end

    assign cmd_ready_a   = !full[0];
    assign cmd_ready_b   = !full[1];
    assign rsp_valid_a   = rsp_v_q[0] | nop_rsp[0];
    assign rsp_ack_a     = rsp_ack_q[0] | nop_rsp[0];
    assign rsp_valid_b   = rsp_v_q[1] | nop_rsp[1];
    assign rsp_ack_b     = rsp_ack_q[1] | nop_rsp[1];
    assign req           = req_q;
    assign ctrlA         = ctrl_q[0];
    assign ctrlB         = ctrl_q[1];
    assign alarm_pending = pend_q;
    assign alarm_irq     = |pend_q;

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Directed bench for ats21_cmd_issuer with hand-computed expectations.
// Bus beats and responses are logged once per cycle, 1 ns after the edge.
module tb_ats21_cmd_issuer;

`ifdef ATS21_ISSUER_RETRY_EN
    localparam int NTX = 4;
`else
    localparam int NTX = 1;
`endif

    logic        clk_1x;
    logic        reset;
    logic        cmd_valid_a, cmd_valid_b;
    logic [31:0] cmd_data_a, cmd_data_b;
    logic        cmd_ready_a, cmd_ready_b;
    logic        rsp_valid_a, rsp_ack_a, rsp_valid_b, rsp_ack_b;
    logic        req;
    logic [15:0] ctrlA, ctrlB;
    logic [1:0]  stat;
    logic [23:0] data, alarm_clr, alarm_pending;
    logic        alarm_irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] beats[$];
    logic        ra[$], rb[$];
    int          ca[$], cb[$];

    ats21_cmd_issuer dut (
        .clk_1x        (clk_1x),
        .reset         (reset),
        .cmd_valid_a   (cmd_valid_a),
        .cmd_data_a    (cmd_data_a),
        .cmd_ready_a   (cmd_ready_a),
        .cmd_valid_b   (cmd_valid_b),
        .cmd_data_b    (cmd_data_b),
        .cmd_ready_b   (cmd_ready_b),
        .rsp_valid_a   (rsp_valid_a),
        .rsp_ack_a     (rsp_ack_a),
        .rsp_valid_b   (rsp_valid_b),
        .rsp_ack_b     (rsp_ack_b),
        .req           (req),
        .ctrlA         (ctrlA),
        .ctrlB         (ctrlB),
        .stat          (stat),
        .data          (data),
        .alarm_clr     (alarm_clr),
        .alarm_pending (alarm_pending),
        .alarm_irq     (alarm_irq)
    );

    initial clk_1x = 1'b0;
    always #5 clk_1x = ~clk_1x;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1x);
        #1;
        cyc++;
        if (req) beats.push_back({ctrlA, ctrlB});
        if (rsp_valid_a) begin
            ra.push_back(rsp_ack_a);
            ca.push_back(cyc);
        end
        if (rsp_valid_b) begin
            rb.push_back(rsp_ack_b);
            cb.push_back(cyc);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        beats.delete();
        ra.delete();
        rb.delete();
        ca.delete();
        cb.delete();
    endtask

    initial begin
        int k;
        int errs;
        logic fire;
        logic saw_full;

        reset       = 1'b1;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        cmd_data_a  = '0;
        cmd_data_b  = '0;
        stat        = 2'b00;
        data        = '0;
        alarm_clr   = '0;
        ticks(2);

        check("rst_req", req, 1'b0);
        check("rst_ctrl", {ctrlA, ctrlB}, 32'h0);
        check("rst_ready", {cmd_ready_a, cmd_ready_b}, 2'b11);
        check("rst_rsp", {rsp_valid_a, rsp_ack_a, rsp_valid_b, rsp_ack_b}, 4'b0);
        check("rst_alarm", {alarm_pending, alarm_irq}, 25'h0);
        reset = 1'b0;
        ticks(2);

        // Single A command, Ack, cycle-exact beats and latency.
        clear_log();
        stat        = 2'b01;
        cmd_valid_a = 1'b1;
        cmd_data_a  = 32'h2200_0005;
        tick();
        cmd_valid_a = 1'b0;
        tick();
        check("t1_hi", {req, ctrlA, ctrlB}, {1'b1, 16'h2200, 16'h0000});
        tick();
        check("t1_lo", {req, ctrlA, ctrlB}, {1'b1, 16'h0005, 16'h0000});
        tick();
        check("t1_resp", {req, ctrlA, ctrlB}, 33'h0);
        tick();
        check("t1_rsp", {rsp_valid_a, rsp_ack_a}, 2'b11);
        tick();
        check("t1_rsp_end", rsp_valid_a, 1'b0);
        ticks(3);
        check("t1_nrsp", ra.size(), 1);
        check("t1_nbeats", beats.size(), 2);

        // Shared A+B transaction.
        clear_log();
        stat        = 2'b11;
        cmd_valid_a = 1'b1;
        cmd_data_a  = 32'hA300_0010;
        cmd_valid_b = 1'b1;
        cmd_data_b  = 32'hA400_0020;
        tick();
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        ticks(8);
        check("t2_nbeats", beats.size(), 2);
        check("t2_beat0", beats.size() > 0 ? beats[0] : 32'hx, 32'hA300_A400);
        check("t2_beat1", beats.size() > 1 ? beats[1] : 32'hx, 32'h0010_0020);
        check("t2_rsp_a", {ra.size() == 1, ra.size() > 0 ? ra[0] : 1'bx}, 2'b11);
        check("t2_rsp_b", {rb.size() == 1, rb.size() > 0 ? rb[0] : 1'bx}, 2'b11);
        check("t2_same_cyc",
              (ca.size() > 0 && cb.size() > 0) ? (ca[0] == cb[0]) : 1'b0, 1'b1);

        // Persistent Nack.
        clear_log();
        stat        = 2'b00;
        cmd_valid_a = 1'b1;
        cmd_data_a  = 32'h6100_0001;
        tick();
        cmd_valid_a = 1'b0;
        ticks(20);
        check("t3_nbeats", beats.size(), 2 * NTX);
        check("t3_beat0", beats.size() > 0 ? beats[0] : 32'hx, 32'h6100_0000);
        check("t3_rsp", {ra.size() == 1, ra.size() > 0 ? ra[0] : 1'bx}, 2'b10);
        check("t3_no_b", rb.size(), 0);

        // Six A commands back to back; ready tracks occupancy.
        clear_log();
        stat     = 2'b01;
        k        = 0;
        errs     = 0;
        saw_full = 1'b0;
        for (int t = 0; t < 40; t++) begin
            cmd_valid_a = k < 6;
            cmd_data_a  = {16'h2000 + 16'(k), 16'h0100 + 16'(k)};
            fire = cmd_valid_a && cmd_ready_a;
            tick();
            if (fire) k++;
            if (cmd_ready_a !== ((k - ra.size()) < 4)) errs++;
            if (!cmd_ready_a) saw_full = 1'b1;
        end
        cmd_valid_a = 1'b0;
        check("t4_pushed", k, 6);
        check("t4_ready_occ", errs, 0);
        check("t4_saw_full", saw_full, 1'b1);
        check("t4_nbeats", beats.size(), 12);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (beats.size() >= 2 * i + 2) begin
                if (beats[2*i] !== {16'h2000 + 16'(i), 16'h0}) errs++;
                if (beats[2*i+1] !== {16'h0100 + 16'(i), 16'h0}) errs++;
            end
        end
        check("t4_order", errs, 0);
        errs = 0;
        foreach (ra[i]) if (ra[i] !== 1'b1) errs++;
        check("t4_nrsp", ra.size(), 6);
        check("t4_all_ack", errs, 0);

        // Nop completes locally without bus activity.
        clear_log();
        cmd_valid_a = 1'b1;
        cmd_data_a  = 32'h0000_1234;
        tick();
        cmd_valid_a = 1'b0;
        ticks(5);
        check("t5_nop_rsp", {ra.size() == 1, ra.size() > 0 ? ra[0] : 1'bx}, 2'b11);
        check("t5_nop_noreq", beats.size(), 0);

        // Alarm capture, hold, clear, set-wins.
        data[3] = 1'b1;
        tick();
        check("al_set", {alarm_pending, alarm_irq}, {24'h8, 1'b1});
        tick();
        data[3] = 1'b0;
        ticks(2);
        check("al_hold", {alarm_pending, alarm_irq}, {24'h8, 1'b1});
        alarm_clr[3] = 1'b1;
        tick();
        alarm_clr[3] = 1'b0;
        check("al_clr", {alarm_pending, alarm_irq}, 25'h0);
        data[3]      = 1'b1;
        alarm_clr[3] = 1'b1;
        tick();
        alarm_clr[3] = 1'b0;
        check("al_set_wins", alarm_pending, 24'h8);
        alarm_clr[3] = 1'b1;
        tick();
        alarm_clr[3] = 1'b0;
        data[3]      = 1'b0;
        check("al_clr2", {alarm_pending, alarm_irq}, 25'h0);

        // Reset during BEAT_LO discards everything.
        stat        = 2'b01;
        cmd_valid_a = 1'b1;
        cmd_data_a  = 32'h2300_0007;
        tick();
        cmd_data_a  = 32'h2300_0008;
        tick();
        cmd_valid_a = 1'b0;
        tick();
        check("rs_in_lo", {req, ctrlA}, {1'b1, 16'h0007});
        clear_log();
        reset = 1'b1;
        #1;
        check("rs_async", {req, ctrlA, ctrlB}, 33'h0);
        tick();
        check("rs_ready", {cmd_ready_a, cmd_ready_b}, 2'b11);
        reset = 1'b0;
        ticks(10);
        check("rs_no_rsp", ra.size() + rb.size(), 0);
        check("rs_no_req", beats.size(), 0);
        cmd_valid_b = 1'b1;
        cmd_data_b  = 32'hE500_0042;
        stat        = 2'b10;
        tick();
        cmd_valid_b = 1'b0;
        ticks(6);
        check("rs_after", {rb.size() == 1, rb.size() > 0 ? rb[0] : 1'bx}, 2'b11);
        check("rs_after_b0", beats.size() > 0 ? beats[0] : 32'hx, 32'h0000_E500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ats21_cmd_issuer.md
# ats21_cmd_issuer

Client-side initiator for the ATS21 timer/alarm device. It accepts 32-bit ATS21 instructions from two independent command sources, A and B, and queues each source in its own FIFO. It serializes queued instructions into the two-beat 16-bit req/ctrlA/ctrlB bus protocol, samples the per-client stat response, and retries on Nack. It also converts the ATS21 24-bit alarm `data` outputs into sticky, clearable alarm events with an interrupt.

## Interface
- FIFO_DEPTH, 4, entries per client command FIFO (power of two, ≥2)
- MAX_RETRY, 3, reissues after Nack before reporting failure
- NUM_ALARMS, 24, width of alarm event vectors

Clock and reset: reset is asynchronous and active-high; the clock is clk_1x.

- clk_1x  in  1  reference clock, same clock that drives the ATS21
- reset  in  1  asynchronous, active-high
- cmd_valid_a / cmd_valid_b  in  1  command offered by client A / B
- cmd_data_a / cmd_data_b  in  32  instruction; opcode is bits [31:29]
- cmd_ready_a / cmd_ready_b  out  1  FIFO not full; transfer when valid&&ready
- rsp_valid_a / rsp_valid_b  out  1  one-cycle completion pulse, one per accepted command, in order
- rsp_ack_a / rsp_ack_b  out  1  1 = Ack, 0 = Nack (qualified by rsp_valid)
- req  out  1  bus request to ATS21
- ctrlA / ctrlB  out  16  instruction beats to ATS21
- stat  in  2  ATS21 status: bit0 = client A, bit1 = client B (1 = Ack)
- data  in  NUM_ALARMS  ATS21 alarm finished bits
- alarm_clr  in  NUM_ALARMS  write-1-to-clear mask for alarm_pending
- alarm_pending  out  NUM_ALARMS  sticky alarm events
- alarm_irq  out  1  OR-reduction of alarm_pending

## Operation
- FSM states: IDLE, BEAT_HI, BEAT_LO, RESP.
- IDLE:
  - A FIFO head with opcode 000 (nop) is popped and completed locally, with rsp_valid=1 and rsp_ack=1 in the same cycle. No bus activity occurs.
  - If either head is a non-nop, or either client has a pending retry, go to BEAT_HI. All participating clients launch together.
- BEAT_HI: req=1; ctrlX=instr[31:16] for each participating client. A non-participating port drives 16'h0000.
- BEAT_LO: req=1; ctrlX=instr[15:0]; non-participating port drives 16'h0000.
- RESP: req=0; ctrl ports 0; stat sampled for participating clients.
  - Ack: pop the command and pulse rsp_valid with rsp_ack=1.
  - Nack: increment that client's retry count. While retry count ≤ MAX_RETRY the client stays pending. Otherwise pop the command, pulse rsp_valid with rsp_ack=0, and zero the count.
  - Next state is BEAT_HI if anything is pending, else IDLE.
- A client whose head is held for retry does not advance. The other client may launch its next command in the same transaction.
- Retry counters are 2 bits wide (sized $clog2(MAX_RETRY+1)). They are per client and cleared on completion.
- FIFO push and pop in the same cycle is legal when the FIFO is full.
- Alarm capture: rising edge of data[i] (current 1, previous 0) sets alarm_pending[i]. alarm_clr[i] clears it. When set and clear coincide, set wins.

## Timing
- Reset values: req=0, ctrlA=ctrlB=0, cmd_ready_*=1, rsp_valid_*=0, rsp_ack_*=0, alarm_pending=0, alarm_irq=0, FSM=IDLE, FIFOs empty, data history=0.
- Reset asserted mid-transaction forces all of the above on the next evaluation, asynchronously. In-flight and queued commands are discarded with no rsp pulse.
- Latency from push into an empty FIFO to rsp_valid on Ack is 4 cycles: push, BEAT_HI, BEAT_LO, RESP. The pulse is registered and appears in the cycle after RESP.
- Back-to-back transactions occupy 3 cycles each. The req=0 cycle in RESP is mandatory.
- stat is treated as valid only in RESP.
- alarm_pending updates 1 cycle after the data edge. alarm_irq is combinational from alarm_pending.

## Configuration
- ATS21_ISSUER_RETRY_EN:
  - Defined: Nack retry as described above.
  - Undefined: retry counters are not built and MAX_RETRY is ignored. Any Nack completes immediately with rsp_ack=0.

## Structure
- ats21_pkg holds:
  - opcode enum (NOP=000, SET_CLK=001, EN_CLK=010, MODE=011, SET_ALM=101, SET_TMR=110, EN_ALM=111)
  - stat enum (Nack=0, Ack=1)
  - issuer FSM state enum
  - NUM_ALARMS and NUM_CLOCKS constants
- One sub-module, ats21_cmd_fifo: synchronous FIFO with parameter DEPTH and WIDTH=32, and ports push, pop, head, full, empty. It is instantiated once per client.

## Test plan
- Push A=32'h2200_0005 (set clock 1) with stat=01 in RESP. Expect req high for 2 cycles with ctrlA=16'h2200 then 16'h0005 and ctrlB=0, then rsp_valid_a=1 and rsp_ack_a=1 exactly once.
- Push A=32'hA300_0010 and B=32'hA400_0020 in the same cycle with stat=11. Expect one shared transaction (ctrlA 16'hA300/16'h0010, ctrlB 16'hA400/16'h0020) and both responses Ack in the same cycle.
- With the macro defined, push A with stat=00 always. Expect 4 transactions (1+MAX_RETRY) and then rsp_ack_a=0. Without the macro, expect 1 transaction and then Nack.
- Push 6 A commands on consecutive cycles. Expect cmd_ready_a low while occupancy=4, all 6 issued in push order, and 6 rsp pulses. Push a nop (32'h0000_1234): expect Ack with no req.
- Drive data[3] high for 2 cycles. Expect alarm_pending[3]=1 and alarm_irq=1 one cycle later, held after data falls. alarm_clr[3] clears both. Set and clear coinciding leaves the bit set.
- Assert reset during BEAT_LO. Expect req=0 and ctrl ports 0 immediately, FIFOs empty, no rsp pulse, and normal operation after release.
